input_debouncer: RTL and testbench

- Consumes the divided slow clock from the clock divider and uses its rising edges as a sampling tick to debounce the raw player push-buttons.
- Produces clean button levels plus single-cycle press/release pulses for the fighting-game control FSM.
- Runs entirely on the fast board clock. The slow clock is treated as data only and is never used as a clock.

---
 rtl/input_debouncer.sv | 114 +++++++++++
 tb/tb_input_debouncer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/input_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : input_debouncer
// Purpose  : Debounces raw push-buttons using slow_clk rising edges as ticks.
//            Emits clean levels plus one-cycle press/release/auto-repeat pulses.
// Revision : 1.0  initial release
// ============================================================================
module input_debouncer #(
    parameter int N_BTN        = 4,
    parameter int STABLE_TICKS = 4,
    parameter int REPEAT_DELAY = 0,
    parameter int REPEAT_RATE  = 2
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             slow_clk,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic             tick
);

    localparam logic [3:0] c_stable     = 4'(STABLE_TICKS);
    localparam logic [7:0] c_rpt_delay  = 8'(REPEAT_DELAY);
    localparam logic [7:0] c_rpt_reload = (REPEAT_RATE >= REPEAT_DELAY) ? 8'd0
                                          : 8'(REPEAT_DELAY - REPEAT_RATE);
    localparam bit         c_rpt_en     = (REPEAT_DELAY > 0);

    logic             r_slow_s1;
    logic             r_slow_s2;
    logic             r_slow_prev;
    logic             r_tick;
    logic             w_tick;
    logic [N_BTN-1:0] r_btn_s1;
    logic [N_BTN-1:0] r_btn_sync;

    // slow_clk is sampled as data; the edge detector drives all debounce state
    assign w_tick = r_slow_s2 & ~r_slow_prev;
    assign tick   = r_tick;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_slow_s1   <= 1'b0;
            r_slow_s2   <= 1'b0;
            r_slow_prev <= 1'b0;
            r_tick      <= 1'b0;
            r_btn_s1    <= '0;
            r_btn_sync  <= '0;
        end else begin
            r_slow_s1   <= slow_clk;
            r_slow_s2   <= r_slow_s1;
            r_slow_prev <= r_slow_s2;
            r_tick      <= w_tick;
            r_btn_s1    <= btn_raw;
            r_btn_sync  <= r_btn_s1;
        end
    end

    generate
        for (genvar i = 0; i < N_BTN; i++) begin : g_btn
            logic [3:0] r_stable_cnt;
            logic [7:0] r_rpt_cnt;
            logic       r_level;
            logic       r_press;
            logic       r_release;
            logic       w_differs;
            logic       w_flip;
            logic       w_rpt_hit;

            assign w_differs = r_btn_sync[i] ^ r_level;
            assign w_flip    = w_tick & w_differs & ((r_stable_cnt + 4'd1) == c_stable);
            // >= rather than == keeps a stray count from ever skipping the reload
            assign w_rpt_hit = c_rpt_en & r_level & w_tick & ~w_flip
                               & (r_rpt_cnt >= (c_rpt_delay - 8'd1));

            always_ff @(posedge clk_in) begin
                if (reset) begin
                    r_stable_cnt <= 4'd0;
                    r_rpt_cnt    <= 8'd0;
                    r_level      <= 1'b0;
                    r_press      <= 1'b0;
                    r_release    <= 1'b0;
                end else begin
                    r_press   <= (w_flip & ~r_level) | w_rpt_hit;
                    r_release <= w_flip & r_level;
                    if (w_flip) begin
                        r_level <= ~r_level;
                    end
                    if (w_tick) begin
                        if (!w_differs || w_flip) begin
                            r_stable_cnt <= 4'd0;
                        end else begin
                            r_stable_cnt <= r_stable_cnt + 4'd1;
                        end
                    end
                    if (!c_rpt_en || !r_level || w_flip) begin
                        r_rpt_cnt <= 8'd0;
                    end else if (w_rpt_hit) begin
                        r_rpt_cnt <= c_rpt_reload;
                    end else if (w_tick) begin
                        r_rpt_cnt <= r_rpt_cnt + 8'd1;
                    end
                end
            end

            assign btn_level[i]   = r_level;
            assign btn_press[i]   = r_press;
            assign btn_release[i] = r_release;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_input_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : tb_input_debouncer
// Purpose  : Directed self-checking bench for input_debouncer (default and
//            auto-repeat configurations driven from a shared clock and tick).
// Revision : 1.0  initial release
// ============================================================================
module tb_input_debouncer;

    logic       clk;
    logic       reset;
    logic       slow_clk;
    logic [3:0] btn_raw;
    logic [3:0] btn_level;
    logic [3:0] btn_press;
    logic [3:0] btn_release;
    logic       tick;
    logic [3:0] btn_raw_r;
    logic [3:0] level_r;
    logic [3:0] press_r;
    logic [3:0] release_r;
    logic       tick_r;

    int n_vectors     = 0;
    int n_miscompares = 0;
    int press_cnt [4] = '{default: 0};
    int rel_cnt   [4] = '{default: 0};
    int rpt_press_cnt = 0;
    int tick_cnt      = 0;

    input_debouncer #(.N_BTN(4), .STABLE_TICKS(4), .REPEAT_DELAY(0), .REPEAT_RATE(2)) dut (
        .clk_in(clk), .reset(reset), .slow_clk(slow_clk), .btn_raw(btn_raw),
        .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release), .tick(tick)
    );

    input_debouncer #(.N_BTN(4), .STABLE_TICKS(4), .REPEAT_DELAY(6), .REPEAT_RATE(2)) dut_rpt (
        .clk_in(clk), .reset(reset), .slow_clk(slow_clk), .btn_raw(btn_raw_r),
        .btn_level(level_r), .btn_press(press_r), .btn_release(release_r), .tick(tick_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // slow_clk period is 8 clk cycles, edges placed away from both clk edges
    initial begin
        slow_clk = 1'b0;
        #3;
        forever #40 slow_clk = ~slow_clk;
    end

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            press_cnt[i] += int'(btn_press[i]);
            rel_cnt[i]   += int'(btn_release[i]);
        end
        rpt_press_cnt += int'(press_r[3]);
        tick_cnt      += int'(tick);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_tick();
        logic found;
        found = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (tick) begin
                found = 1'b1;
                break;
            end
        end
        chk("tick_timeout", 32'(found), 32'd1);
    endtask

    initial begin
        int base_p0;
        int base_p1;
        int base_p2;
        int base_r2;
        int base_rpt;
        int base_tick;
        int lat;
        logic prev_slow;
        logic [3:0] exp_v;

        reset     = 1'b1;
        btn_raw   = 4'b0000;
        btn_raw_r = 4'b0000;

        // reset held across a slow_clk rise: nothing may toggle
        repeat (3) @(negedge clk);
        chk("rst_outputs", {tick, btn_level, btn_press, btn_release}, 32'd0);
        chk("rst_outputs_rpt", {tick_r, level_r, press_r, release_r}, 32'd0);
        repeat (12) @(negedge clk);
        chk("rst_no_tick", 32'(tick_cnt), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_quiet", {tick, btn_level, btn_press, btn_release}, 32'd0);

        prev_slow = slow_clk;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (slow_clk && !prev_slow) break;
            prev_slow = slow_clk;
        end
        lat = 0;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            if (tick) begin
                lat = n;
                break;
            end
        end
        chk("first_tick_lat", 32'(lat), 32'd2);
        @(negedge clk);
        chk("tick_width", 32'(tick), 32'd0);

        // single press on bit 0
        base_p0 = press_cnt[0];
        btn_raw[0] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            wait_tick();
            if (k < 4) begin
                chk("b0_level_early", 32'(btn_level), 32'h0);
                chk("b0_press_early", 32'(btn_press), 32'h0);
            end else begin
                chk("b0_level_rise", 32'(btn_level), 32'h1);
                chk("b0_press", 32'(btn_press), 32'h1);
            end
        end
        @(negedge clk);
        chk("b0_press_width", 32'(btn_press), 32'h0);

        // glitch one tick short of STABLE_TICKS on bit 1
        base_p1 = press_cnt[1];
        btn_raw[1] = 1'b1;
        repeat (3) wait_tick();
        btn_raw[1] = 1'b0;
        repeat (5) wait_tick();
        chk("b1_glitch_level", 32'(btn_level), 32'h1);
        @(negedge clk);
        chk("b1_glitch_pulses", 32'(press_cnt[1] - base_p1), 32'd0);
        chk("b0_press_count", 32'(press_cnt[0] - base_p0), 32'd1);

        // bit 2 press, then bits 0 and 2 released together
        base_p2 = press_cnt[2];
        base_r2 = rel_cnt[2];
        btn_raw[2] = 1'b1;
        repeat (3) wait_tick();
        chk("b2_level_early", 32'(btn_level), 32'h1);
        wait_tick();
        chk("b2_level_rise", 32'(btn_level), 32'h5);
        chk("b2_press", 32'(btn_press), 32'h4);
        btn_raw = 4'b0000;
        for (int k = 1; k <= 4; k++) begin
            wait_tick();
            if (k < 4) begin
                chk("rel_level_early", 32'(btn_level), 32'h5);
                chk("rel_pulse_early", 32'(btn_release), 32'h0);
            end else begin
                chk("rel_level_fall", 32'(btn_level), 32'h0);
                chk("rel_pulse", 32'(btn_release), 32'h5);
                chk("rel_no_press", 32'(btn_press), 32'h0);
            end
        end
        @(negedge clk);
        chk("rel_width", 32'(btn_release), 32'h0);
        @(negedge clk);
        chk("b2_press_count", 32'(press_cnt[2] - base_p2), 32'd1);
        chk("b2_rel_count", 32'(rel_cnt[2] - base_r2), 32'd1);

        // auto-repeat: delay 6, rate 2
        base_rpt = rpt_press_cnt;
        btn_raw_r[3] = 1'b1;
        repeat (3) wait_tick();
        wait_tick();
        chk("rpt_level_rise", 32'(level_r), 32'h8);
        chk("rpt_press_rise", 32'(press_r), 32'h8);
        for (int k = 1; k <= 20; k++) begin
            wait_tick();
            exp_v = (k >= 6 && (k % 2) == 0) ? 4'h8 : 4'h0;
            chk($sformatf("rpt_tick%0d", k), 32'(press_r), 32'(exp_v));
        end
        @(negedge clk);
        @(negedge clk);
        chk("rpt_press_count", 32'(rpt_press_cnt - base_rpt), 32'd9);
        btn_raw_r[3] = 1'b0;
        // repeat keeps running until the level actually falls
        for (int k = 1; k <= 4; k++) begin
            wait_tick();
            exp_v = (k == 2) ? 4'h8 : 4'h0;
            chk($sformatf("rpt_rel_press%0d", k), 32'(press_r), 32'(exp_v));
        end
        chk("rpt_rel_level", 32'(level_r), 32'h0);
        chk("rpt_rel_pulse", 32'(release_r), 32'h8);

        // reset two ticks into a debounce discards the partial count
        btn_raw[0] = 1'b1;
        repeat (2) wait_tick();
        chk("mid_level", 32'(btn_level), 32'h0);
        @(negedge clk);
        base_p0   = press_cnt[0];
        base_tick = tick_cnt;
        reset = 1'b1;
        repeat (20) @(negedge clk);
        chk("mid_rst_outputs", {tick, btn_level, btn_press, btn_release}, 32'd0);
        chk("mid_rst_no_press", 32'(press_cnt[0] - base_p0), 32'd0);
        chk("mid_rst_no_tick", 32'(tick_cnt - base_tick), 32'd0);
        reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            wait_tick();
            if (k < 4) begin
                chk("mid_level_early", 32'(btn_level), 32'h0);
                chk("mid_press_early", 32'(btn_press), 32'h0);
            end else begin
                chk("mid_level_rise", 32'(btn_level), 32'h1);
                chk("mid_press", 32'(btn_press), 32'h1);
            end
        end
        @(negedge clk);
        chk("mid_press_width", 32'(btn_press), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
`default_nettype wire
